// File: rtl/sme_line_feeder_if.sv
// Byte-stream, matcher and result signals of the string-matching front end.
// slave = the feeder itself, master = whatever drives the stream and the matcher replies.
interface sme_line_feeder_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] chardata;
  logic       isstring;
  logic       ispattern;
  logic       sme_valid;
  logic       sme_match;
  logic [4:0] sme_match_index;
  logic       res_valid;
  logic       res_match;
  logic [4:0] res_index;
  logic       err;
  logic       busy;

  modport slave (
    input  in_data, in_valid, sme_valid, sme_match, sme_match_index,
    output in_ready, chardata, isstring, ispattern, res_valid, res_match,
           res_index, err, busy
  );

  modport master (
    output in_data, in_valid, sme_valid, sme_match, sme_match_index,
    input  in_ready, chardata, isstring, ispattern, res_valid, res_match,
           res_index, err, busy
  );
endinterface

// File: rtl/sme_line_feeder.sv
// Buffers one tagged string line and one pattern line, then replays them to the
// matcher as a gap-free isstring/ispattern burst and waits for its result.
module sme_line_feeder #(
  parameter int STR_MAX = 32,
  parameter int PAT_MAX = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  sme_line_feeder_if.slave     bus,
  output logic [2:0]           state_dbg
);
  localparam int SW  = $clog2(STR_MAX + 1);
  localparam int PW  = $clog2(PAT_MAX + 1);
  localparam int SAW = $clog2(STR_MAX);
  localparam int PAW = $clog2(PAT_MAX);
  localparam logic [7:0]    TAG_S    = 8'h53;
  localparam logic [7:0]    TAG_P    = 8'h50;
  localparam logic [7:0]    LF       = 8'h0A;
  localparam logic [SW-1:0] STR_FULL = SW'(STR_MAX);
  localparam logic [PW-1:0] PAT_FULL = PW'(PAT_MAX);

  typedef enum logic [2:0] {RX, DISCARD, PLAY_STR, PLAY_PAT, WAIT_RES} state_t;

  state_t        state, state_n;
  logic          in_line, in_line_n, sel_pat, sel_pat_n;
  logic          str_loaded, str_loaded_n, str_pending, str_pending_n;
  logic [SW-1:0] str_cnt, str_cnt_n, play_idx, play_idx_n;
  logic [PW-1:0] pat_cnt, pat_cnt_n;
  logic [7:0]    chardata_q, chardata_n;
  logic          isstring_q, isstring_n, ispattern_q, ispattern_n;
  logic          res_valid_q, res_valid_n, res_match_q, res_match_n;
  logic [4:0]    res_index_q, res_index_n;
  logic          err_q, err_n;
  logic          wr_str, wr_pat, accept;
  logic [7:0]    str_buf [STR_MAX];
  logic [7:0]    pat_buf [PAT_MAX];

  // Handshake: a byte transfers on a rising edge where in_valid && in_ready;
  // in_ready depends only on state, never on in_valid.
  assign bus.in_ready  = (state == RX) || (state == DISCARD);
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.busy      = (state != RX);
  assign bus.chardata  = chardata_q;
  assign bus.isstring  = isstring_q;
  assign bus.ispattern = ispattern_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_match = res_match_q;
  assign bus.res_index = res_index_q;
  assign bus.err       = err_q;
  assign state_dbg     = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= RX;
      in_line     <= 1'b0;
      sel_pat     <= 1'b0;
      str_loaded  <= 1'b0;
      str_pending <= 1'b0;
      str_cnt     <= '0;
      pat_cnt     <= '0;
      play_idx    <= '0;
      chardata_q  <= '0;
      isstring_q  <= 1'b0;
      ispattern_q <= 1'b0;
      res_valid_q <= 1'b0;
      res_match_q <= 1'b0;
      res_index_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state       <= state_n;
      in_line     <= in_line_n;
      sel_pat     <= sel_pat_n;
      str_loaded  <= str_loaded_n;
      str_pending <= str_pending_n;
      str_cnt     <= str_cnt_n;
      pat_cnt     <= pat_cnt_n;
      play_idx    <= play_idx_n;
      chardata_q  <= chardata_n;
      isstring_q  <= isstring_n;
      ispattern_q <= ispattern_n;
      res_valid_q <= res_valid_n;
      res_match_q <= res_match_n;
      res_index_q <= res_index_n;
      err_q       <= err_n;
    end
  end

  // Line buffers keep their contents across reset.
  always_ff @(posedge clk) begin
    if (wr_str) str_buf[str_cnt[SAW-1:0]] <= bus.in_data;
    if (wr_pat) pat_buf[pat_cnt[PAW-1:0]] <= bus.in_data;
  end

  always_comb begin
    state_n       = state;
    in_line_n     = in_line;
    sel_pat_n     = sel_pat;
    str_loaded_n  = str_loaded;
    str_pending_n = str_pending;
    str_cnt_n     = str_cnt;
    pat_cnt_n     = pat_cnt;
    play_idx_n    = play_idx;
    chardata_n    = 8'h00;
    isstring_n    = 1'b0;
    ispattern_n   = 1'b0;
    res_valid_n   = 1'b0;
    res_match_n   = res_match_q;
    res_index_n   = res_index_q;
    err_n         = 1'b0;
    wr_str        = 1'b0;
    wr_pat        = 1'b0;

    case (state)
      RX: if (accept) begin
        if (!in_line) begin
          case (bus.in_data)
            TAG_S: begin
              in_line_n     = 1'b1;
              sel_pat_n     = 1'b0;
              str_loaded_n  = 1'b0;
              str_pending_n = 1'b0;
              str_cnt_n     = '0;
            end
            TAG_P: begin
              in_line_n = 1'b1;
              sel_pat_n = 1'b1;
              pat_cnt_n = '0;
            end
            LF:      err_n = 1'b1;
            default: begin
              err_n   = 1'b1;
              state_n = DISCARD;
            end
          endcase
        end else if (bus.in_data == LF) begin
          in_line_n = 1'b0;
          if (sel_pat ? (pat_cnt == '0) : (str_cnt == '0)) begin
            err_n = 1'b1;
          end else if (!sel_pat) begin
            str_loaded_n  = 1'b1;
            str_pending_n = 1'b1;
          end else if (str_pending) begin
            // First played byte is registered on the terminator edge itself.
            state_n    = PLAY_STR;
            chardata_n = str_buf[0];
            isstring_n = 1'b1;
            play_idx_n = SW'(1);
          end else if (str_loaded) begin
            state_n     = PLAY_PAT;
            chardata_n  = pat_buf[0];
            ispattern_n = 1'b1;
            play_idx_n  = SW'(1);
          end else begin
            err_n = 1'b1;
          end
        end else if (!sel_pat) begin
          if (str_cnt == STR_FULL) begin
            err_n     = 1'b1;
            in_line_n = 1'b0;
            state_n   = DISCARD;
          end else begin
            wr_str    = 1'b1;
            str_cnt_n = str_cnt + SW'(1);
          end
        end else begin
          if (pat_cnt == PAT_FULL) begin
            err_n     = 1'b1;
            in_line_n = 1'b0;
            state_n   = DISCARD;
          end else begin
            wr_pat    = 1'b1;
            pat_cnt_n = pat_cnt + PW'(1);
          end
        end
      end
      DISCARD: if (accept && bus.in_data == LF) state_n = RX;
      PLAY_STR: begin
        if (play_idx < str_cnt) begin
          chardata_n = str_buf[play_idx[SAW-1:0]];
          isstring_n = 1'b1;
          play_idx_n = play_idx + SW'(1);
        end else begin
          // Hand straight over to the pattern so the matcher sees no gap.
          chardata_n    = pat_buf[0];
          ispattern_n   = 1'b1;
          play_idx_n    = SW'(1);
          str_pending_n = 1'b0;
          state_n       = PLAY_PAT;
        end
      end
      PLAY_PAT: begin
        if (play_idx < SW'(pat_cnt)) begin
          chardata_n  = pat_buf[play_idx[PAW-1:0]];
          ispattern_n = 1'b1;
          play_idx_n  = play_idx + SW'(1);
        end else begin
          state_n = WAIT_RES;
        end
      end
      WAIT_RES: if (bus.sme_valid) begin
        res_valid_n = 1'b1;
        res_match_n = bus.sme_match;
        res_index_n = bus.sme_match_index;
        state_n     = RX;
      end
      default: state_n = RX;
    endcase
  end
endmodule

// File: tb/tb_sme_line_feeder.sv
// Directed bench for sme_line_feeder: line framing, replay bursts, errors and reset.
module tb_sme_line_feeder;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] state_dbg;
  int         total = 0;
  int         bad = 0;
  logic [7:0] exp_str_q[$];
  logic [7:0] exp_pat_q[$];

  sme_line_feeder_if bif();

  sme_line_feeder dut (
    .clk       (clk),
    .reset     (rst_n),
    .bus       (bif),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    bif.in_data  = b;
    bif.in_valid = 1'b1;
    step();
    bif.in_valid = 1'b0;
    bif.in_data  = 8'h00;
  endtask

  task automatic send_line(input logic [7:0] tag, input string s);
    send(tag);
    for (int i = 0; i < s.len(); i++) send(s[i]);
    send(8'h0A);
  endtask

  task automatic play_check();
    logic [7:0] b;
    while (exp_str_q.size() > 0) begin
      b = exp_str_q.pop_front();
      chk("str_isstring", bif.isstring, 1);
      chk("str_ispattern", bif.ispattern, 0);
      chk("str_byte", bif.chardata, b);
      step();
    end
    while (exp_pat_q.size() > 0) begin
      b = exp_pat_q.pop_front();
      chk("pat_ispattern", bif.ispattern, 1);
      chk("pat_isstring", bif.isstring, 0);
      chk("pat_byte", bif.chardata, b);
      step();
    end
    chk("end_isstring", bif.isstring, 0);
    chk("end_ispattern", bif.ispattern, 0);
    chk("end_chardata", bif.chardata, 8'h00);
    chk("end_busy", bif.busy, 1);
    chk("end_in_ready", bif.in_ready, 0);
  endtask

  task automatic result(input logic m, input logic [4:0] idx);
    bif.sme_valid       = 1'b1;
    bif.sme_match       = m;
    bif.sme_match_index = idx;
    step();
    bif.sme_valid = 1'b0;
    chk("res_valid_pulse", bif.res_valid, 1);
    chk("res_match", bif.res_match, m);
    chk("res_index", bif.res_index, idx);
    chk("res_busy", bif.busy, 0);
    chk("res_in_ready", bif.in_ready, 1);
    step();
    chk("res_valid_drop", bif.res_valid, 0);
  endtask

  initial begin
    bif.in_data         = 8'h00;
    bif.in_valid        = 1'b0;
    bif.sme_valid       = 1'b0;
    bif.sme_match       = 1'b0;
    bif.sme_match_index = 5'd0;
    rst_n = 1'b0;
    repeat (3) step();
    chk("rst_in_ready", bif.in_ready, 1);
    chk("rst_chardata", bif.chardata, 8'h00);
    chk("rst_isstring", bif.isstring, 0);
    chk("rst_ispattern", bif.ispattern, 0);
    chk("rst_res_valid", bif.res_valid, 0);
    chk("rst_res_match", bif.res_match, 0);
    chk("rst_res_index", bif.res_index, 0);
    chk("rst_err", bif.err, 0);
    chk("rst_busy", bif.busy, 0);
    chk("rst_state", state_dbg, 0);
    rst_n = 1'b1;
    step();

    // Pattern with no string held
    send_line(8'h50, "a");
    chk("nostr_err", bif.err, 1);
    chk("nostr_ispattern", bif.ispattern, 0);
    chk("nostr_in_ready", bif.in_ready, 1);
    chk("nostr_busy", bif.busy, 0);
    step();
    chk("nostr_err_drop", bif.err, 0);

    // String then pattern: full burst
    send_line(8'h53, "ab cd");
    chk("sload_busy", bif.busy, 0);
    chk("sload_err", bif.err, 0);
    chk("sload_isstring", bif.isstring, 0);
    exp_str_q = '{8'h61, 8'h62, 8'h20, 8'h63, 8'h64};
    exp_pat_q = '{8'h5E, 8'h63};
    send_line(8'h50, "^c");
    play_check();
    step();
    step();
    chk("wait_busy", bif.busy, 1);
    result(1'b1, 5'd3);

    // Matcher strobe outside WAIT_RES is ignored
    bif.sme_valid = 1'b1;
    bif.sme_match = 1'b0;
    bif.sme_match_index = 5'd7;
    step();
    bif.sme_valid = 1'b0;
    chk("idle_res_valid", bif.res_valid, 0);
    chk("idle_res_index", bif.res_index, 3);
    chk("idle_res_match", bif.res_match, 1);

    // Reused string: pattern only
    exp_pat_q = '{8'h64, 8'h24};
    send_line(8'h50, "d$");
    play_check();
    result(1'b0, 5'd9);

    // String overflow on the 33rd payload byte
    send(8'h53);
    for (int i = 0; i < 32; i++) send(8'h61 + 8'(i % 26));
    chk("ovf_pre_err", bif.err, 0);
    send(8'h78);
    chk("ovf_err", bif.err, 1);
    chk("ovf_busy", bif.busy, 1);
    chk("ovf_in_ready", bif.in_ready, 1);
    send(8'h0A);
    chk("ovf_back_rx", bif.busy, 0);
    chk("ovf_err_drop", bif.err, 0);
    send_line(8'h50, "zz");
    chk("ovf_pat_err", bif.err, 1);
    chk("ovf_pat_ispattern", bif.ispattern, 0);
    chk("ovf_pat_busy", bif.busy, 0);

    // Full 32-byte string with in_valid every other cycle
    send(8'h53);
    for (int i = 0; i < 32; i++) begin
      bif.in_data  = 8'h41 + 8'(i);
      bif.in_valid = 1'b1;
      step();
      bif.in_valid = 1'b0;
      step();
      exp_str_q.push_back(8'h41 + 8'(i));
    end
    send(8'h0A);
    chk("full_err", bif.err, 0);
    exp_pat_q = '{8'h71};
    send_line(8'h50, "q");
    play_check();
    result(1'b1, 5'd31);

    // Unknown tag and bare terminator
    send(8'h41);
    chk("badtag_err", bif.err, 1);
    chk("badtag_busy", bif.busy, 1);
    send(8'h6B);
    chk("discard_err", bif.err, 0);
    send(8'h0A);
    chk("discard_done", bif.busy, 0);
    send(8'h0A);
    chk("lftag_err", bif.err, 1);
    chk("lftag_busy", bif.busy, 0);
    chk("lftag_in_ready", bif.in_ready, 1);

    // Reset during the third pattern byte
    send_line(8'h50, "wxyz");
    chk("mid_p0", bif.chardata, 8'h77);
    step();
    chk("mid_p1", bif.chardata, 8'h78);
    step();
    chk("mid_p2_flag", bif.ispattern, 1);
    chk("mid_p2", bif.chardata, 8'h79);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ispattern", bif.ispattern, 0);
    chk("arst_isstring", bif.isstring, 0);
    chk("arst_chardata", bif.chardata, 8'h00);
    chk("arst_busy", bif.busy, 0);
    chk("arst_in_ready", bif.in_ready, 1);
    chk("arst_res_index", bif.res_index, 0);
    chk("arst_res_match", bif.res_match, 0);
    step();
    #2 rst_n = 1'b1;
    step();
    bif.sme_valid = 1'b1;
    step();
    bif.sme_valid = 1'b0;
    chk("arst_no_res", bif.res_valid, 0);
    send_line(8'h50, "ab");
    chk("arst_pat_err", bif.err, 1);
    chk("arst_pat_ispattern", bif.ispattern, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
